// File: rtl/extcall_pkg.sv
// rtl/extcall_pkg.sv - shared extcall stream width and stored-beat entry type
package extcall_pkg;

    localparam int EXTCALL_AXIS_W = 32;

    typedef struct packed {
        logic                      last;
        logic [EXTCALL_AXIS_W-1:0] data;
    } extcall_entry_t;

endpackage

// File: rtl/m_fifo_ram.sv
// rtl/m_fifo_ram.sv - DEPTH x W storage array, synchronous write, asynchronous read
module m_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 33
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] mem [DEPTH];

    // No reset: contents are only ever observed behind a valid pointer range.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/m_extcall_tx_fifo.sv
// rtl/m_extcall_tx_fifo.sv - extcall stream buffer; EXTCALL_TX_STORE_FWD_EN selects store-and-forward
module m_extcall_tx_fifo
    import extcall_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = EXTCALL_AXIS_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [DATA_W-1:0]      i_s_axis_tdata,
    input  logic                   i_s_axis_tlast,
    input  logic                   i_s_axis_tvalid,
    output logic                   o_s_axis_tready,
    output logic [DATA_W-1:0]      o_m_axis_tdata,
    output logic                   o_m_axis_tlast,
    output logic                   o_m_axis_tvalid,
    input  logic                   i_m_axis_tready,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DATA_W:0] rd_entry;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign o_s_axis_tready = i_rst_n && !full;
    assign push            = i_s_axis_tvalid && o_s_axis_tready;
    assign pop             = o_m_axis_tvalid && i_m_axis_tready;
    assign o_level         = wr_ptr - rd_ptr;

    assign o_m_axis_tdata  = empty ? '0 : rd_entry[DATA_W-1:0];
    assign o_m_axis_tlast  = !empty && rd_entry[DATA_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

`ifdef EXTCALL_TX_STORE_FWD_EN
    logic [PW-1:0] pkt_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt <= '0;
        end else begin
            case ({push && i_s_axis_tlast, pop && o_m_axis_tlast})
                2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Both terms can only fall through a pop, so tvalid needs no extra hold state.
    assign o_m_axis_tvalid = !empty && ((pkt_cnt != '0) || full);
`else
    assign o_m_axis_tvalid = !empty;
`endif

    m_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (DATA_W + 1)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr[AW-1:0]),
        .i_wdata ({i_s_axis_tlast, i_s_axis_tdata}),
        .i_raddr (rd_ptr[AW-1:0]),
        .o_rdata (rd_entry)
    );

endmodule

// File: doc/m_extcall_tx_fifo.md
# m_extcall_tx_fifo

AXI-Stream buffer between `m_extcall_controller`'s master stream and the host-facing stream interconnect. It absorbs bursts of extcall beats (putc, log strings, beep, exit), so a slow host `tready` does not stall the controller once per beat. It forwards every beat's data and `tlast` unchanged and in order. Build-time store-and-forward mode releases only complete packets.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two and at least 2.
- `DATA_W`, 32: width of `tdata`; must match the controller's `o_m_axis_tdata`.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_s_axis_tdata`  in  DATA_W  upstream beat data, from the controller.
- `i_s_axis_tlast`  in  1  upstream end-of-packet marker.
- `i_s_axis_tvalid`  in  1  upstream beat valid.
- `o_s_axis_tready`  out  1  buffer can accept a beat.
- `o_m_axis_tdata`  out  DATA_W  downstream beat data, to the host.
- `o_m_axis_tlast`  out  1  downstream end-of-packet marker.
- `o_m_axis_tvalid`  out  1  downstream beat valid.
- `i_m_axis_tready`  in  1  host accepts a beat.
- `o_level`  out  $clog2(DEPTH)+1  number of stored beats, 0..DEPTH.

## Operation
- Storage is a circular array of DEPTH entries, each `{tlast, tdata}`.
- Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits; the extra MSB is a wrap bit.
- Empty when `wr_ptr == rd_ptr`.
- Full when the pointers differ only in the MSB.
- `o_level = wr_ptr - rd_ptr`, computed modulo 2^($clog2(DEPTH)+1).
- Push: on a rising edge with `i_s_axis_tvalid && o_s_axis_tready`, write the entry at `wr_ptr[low]` and increment `wr_ptr`.
- Pop: on a rising edge with `o_m_axis_tvalid && i_m_axis_tready`, increment `rd_ptr`.
- `o_s_axis_tready = i_rst_n && !full`. There is no write-through when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle (neither full nor empty): both happen; `o_level` is unchanged.
- Pointers wrap naturally, index `DEPTH-1` to `0`, with the MSB toggling.
- `o_m_axis_tdata` and `o_m_axis_tlast` are read combinationally from the entry at `rd_ptr[low]`.
- `o_m_axis_tdata` and `o_m_axis_tlast` are `'0` when empty, never X.
- Default mode (macro undefined): `o_m_axis_tvalid = !empty`.
- Reset assertion at any time, including mid-packet:
  - Pointers are cleared immediately; stored beats are discarded.
  - `o_m_axis_tvalid` = 0 and `o_s_axis_tready` = 0 while `i_rst_n` is low.
  - `o_level` = 0.
  - Array contents are not cleared.

## Timing
- Reset values: `o_m_axis_tvalid` 0, `o_m_axis_tdata` 0, `o_m_axis_tlast` 0, `o_s_axis_tready` 0, `o_level` 0.
- `o_s_axis_tready` rises combinationally on `i_rst_n` release; the first push can happen on the next edge.
- Latency: a beat pushed at edge N has `o_m_axis_tvalid` high after edge N and can be popped at edge N+1. Minimum latency is 1 cycle; there is no same-cycle bypass.
- Throughput: 1 beat/cycle sustained when both sides are ready.
- AXI-Stream rules:
  - Once `o_m_axis_tvalid` is high, it and `tdata`/`tlast` stay stable until a pop.
  - `o_m_axis_tvalid` never depends combinationally on `i_m_axis_tready`.
- `o_s_axis_tready` drops in the same cycle `o_level` reaches DEPTH; a pop at that edge re-raises it one cycle later.

## Configuration
- `EXTCALL_TX_STORE_FWD_EN` defined: store-and-forward mode.
  - Add a `pkt_cnt` register, $clog2(DEPTH)+1 bits, reset 0.
  - `pkt_cnt` increments on a push with `tlast=1` and decrements on a pop with `tlast=1`. Both in the same cycle leave it unchanged.
  - `o_m_axis_tvalid = !empty && (pkt_cnt != 0 || full)`.
  - The `full` term is a deadlock escape: a packet longer than DEPTH drains in cut-through.
  - Once raised, `tvalid` stays high until the pop, even if the escape condition ends.
- Undefined: no `pkt_cnt`; plain FIFO behaviour as in Operation.

## Structure
- `extcall_pkg` holds:
  - `EXTCALL_AXIS_W = 32`.
  - A typedef for the stored entry, `{logic last; logic [EXTCALL_AXIS_W-1:0] data;}`.
- The controller and this FIFO share those definitions.
- Storage goes in one sub-module, `m_fifo_ram`: a DEPTH x (DATA_W+1) array with synchronous write and asynchronous read, reusable by other stream buffers.
- Pointer, flag and packet-count logic stays in the top module.

## Test plan
- Reset, then push 3 beats `0x41`, `0x42`, `0x43` (tlast=1) with host ready → `o_level` peaks at 1; output order `0x41`, `0x42`, `0x43`, each one cycle after its push.
- Host `tready=0`, push 16 beats 0..15 → `o_level` reaches 16 and `o_s_axis_tready` goes 0. Then host ready → beats 0..15 out in order on 16 consecutive cycles, with wrap-around exercised.
- Full FIFO, upstream offers beat 16 while the host pops in the same cycle → beat 16 is accepted one cycle later, never lost or duplicated.
- Log sequence `0x0`, 9 chars, `0x0` with host `tready` toggling every 3 cycles → exact 11-beat order, `tlast=1` on each, and `tdata` stable while stalled.
- Assert `i_rst_n=0` with 5 beats stored and `tvalid` high → `tvalid`, `tready` and `o_level` are 0 asynchronously, before the next edge. After release, push 1 beat → only that beat emerges.
- With `EXTCALL_TX_STORE_FWD_EN` defined:
  - Push 3 beats with tlast 0,0,1 → `tvalid` stays 0 until after the third push, then 3 beats stream out.
  - Push 16 beats with tlast=0 → escape opens at full and beats drain.
